core_ctrl_scb_mp: RTL

Parametrised multi-retire scoreboard for RAW/WAW hazard control at the issue stage. It keeps a per-register outstanding-write counter, so one register can have several in-flight writers when WAW issue is enabled. It accepts one issue per cycle through a valid/ready handshake and NRET retire (writeback) events per cycle. It also supports pipeline flush and flags retire underflow as an error. It sits between decode/issue and the execute/writeback pipes and replaces the single-bit scoreboard.

---
 rtl/core_ctrl_scb_mp_if.sv | 29 ++
 rtl/core_ctrl_scb_mp.sv | 91 +++++++++
 2 files changed

// File: rtl/core_ctrl_scb_mp_if.sv
// Issue and retire bundle between decode/issue and the hazard scoreboard.
// The master drives issue requests and writeback retires; the slave answers with emit_ready.
interface core_ctrl_scb_mp_if #(
    parameter int IDXW = 5,
    parameter int NRET = 2
);
    logic                 emit_valid;
    logic                 emit_ready;
    logic [IDXW-1:0]      emit_rs1_idx;
    logic                 emit_rs1_used;
    logic [IDXW-1:0]      emit_rs2_idx;
    logic                 emit_rs2_used;
    logic [IDXW-1:0]      emit_rd_idx;
    logic                 emit_rd_wen;
    logic [NRET-1:0]      ret_valid;
    logic [NRET*IDXW-1:0] ret_idx;

    modport master (
        output emit_valid, emit_rs1_idx, emit_rs1_used, emit_rs2_idx, emit_rs2_used,
               emit_rd_idx, emit_rd_wen, ret_valid, ret_idx,
        input  emit_ready
    );

    modport slave (
        input  emit_valid, emit_rs1_idx, emit_rs1_used, emit_rs2_idx, emit_rs2_used,
               emit_rd_idx, emit_rd_wen, ret_valid, ret_idx,
        output emit_ready
    );
endinterface

// File: rtl/core_ctrl_scb_mp.sv
// Multi-retire RAW/WAW scoreboard: one pending-write counter per architectural register,
// one issue per cycle, NRET retires per cycle, synchronous flush and a sticky underflow flag.
module core_ctrl_scb_mp #(
    parameter int NREG      = 32,
    parameter int IDXW      = 5,
    parameter int NRET      = 2,
    parameter int CNTW      = 2,
    parameter int ALLOW_WAW = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   err_clr,
    core_ctrl_scb_mp_if.slave      bus,
    output logic [NREG-1:0]        busy_vec,
    output logic                   err_underflow
);
    localparam int SUMW = CNTW + 1 + $clog2(NRET + 1);
    localparam logic [CNTW-1:0] CMAX = '1;

    logic [CNTW-1:0] cnt_q [NREG];
    logic [CNTW-1:0] cnt_d [NREG];
    logic            err_q, err_d;
    logic            uflow;
    logic            fire;
    logic [IDXW-1:0] rs1_e, rs2_e, rd_e;
    logic            rs1_ok, rs2_ok, rd_ok;

    // Indices beyond the register file alias to the untracked zero register.
    function automatic logic [IDXW-1:0] eff_idx(input logic [IDXW-1:0] i);
        return (int'(i) >= NREG) ? '0 : i;
    endfunction

    always_comb begin
        rs1_e  = eff_idx(bus.emit_rs1_idx);
        rs2_e  = eff_idx(bus.emit_rs2_idx);
        rd_e   = eff_idx(bus.emit_rd_idx);
        rs1_ok = !bus.emit_rs1_used || rs1_e == '0 || cnt_q[rs1_e] == '0;
        rs2_ok = !bus.emit_rs2_used || rs2_e == '0 || cnt_q[rs2_e] == '0;
        if (ALLOW_WAW != 0)
            rd_ok = !bus.emit_rd_wen || rd_e == '0 || cnt_q[rd_e] != CMAX;
        else
            rd_ok = !bus.emit_rd_wen || rd_e == '0 || cnt_q[rd_e] == '0;
        bus.emit_ready = !flush_i && rs1_ok && rs2_ok && rd_ok;
    end

    assign fire = bus.emit_valid && bus.emit_ready;

    always_comb begin
        logic [SUMW-1:0] tot;
        logic [SUMW-1:0] dec;
        tot   = '0;
        dec   = '0;
        uflow = 1'b0;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            tot = SUMW'(cnt_q[r]) + SUMW'(fire && bus.emit_rd_wen && rd_e == IDXW'(r));
            dec = '0;
            for (int k = 0; k < NRET; k++) begin
                if (bus.ret_valid[k] && eff_idx(bus.ret_idx[k*IDXW +: IDXW]) == IDXW'(r))
                    dec = dec + SUMW'(1);
            end
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (dec > tot) begin
                cnt_d[r] = '0;
                uflow    = 1'b1;
            end else begin
                cnt_d[r] = CNTW'(tot - dec);
            end
        end
        err_d = uflow || (err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NREG; r++) busy_vec[r] = (cnt_q[r] != '0);
    end

    assign err_underflow = err_q;
endmodule
